// File: rtl/data_mem_responder.sv
// Word-addressed data memory responder for the multicycle MIPS control path.
// Serves one read or write request at a time, with fixed read and write latencies.
module data_mem_responder #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned WRITE_LAT = 1
) (
  input  logic        Clk,
  input  logic        Reset_signal,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        rdata_valid,
  output logic        write_done,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  ReadCnt  = 4'(READ_LAT - 1);
  localparam logic [3:0]  WriteCnt = 4'(WRITE_LAT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StReadWait,
    StWriteWait
  } state_e;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [29:0]   idx_q;
  logic [31:0]   wdata_q;
  logic [31:0]   mem [DEPTH];

  logic          in_range;
  logic [AW-1:0] widx;
  logic          mem_we;

  // Full-width index compare so huge addresses never alias into the array.
  assign in_range = ({2'b00, idx_q} < 32'(DEPTH));
  assign widx     = idx_q[AW-1:0];
  assign mem_we   = !Reset_signal && (state_q == StWriteWait) && (cnt_q == 4'd0) && in_range;

  // Storage is deliberately left out of reset.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[widx] <= wdata_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset_signal) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      idx_q       <= 30'd0;
      wdata_q     <= 32'd0;
      ReadData    <= 32'd0;
      rdata_valid <= 1'b0;
      write_done  <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      write_done  <= 1'b0;
      err         <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            if (Address[1:0] != 2'b00) begin
              err <= 1'b1;
            end else begin
              idx_q   <= Address[31:2];
              wdata_q <= WriteData;
              busy    <= 1'b1;
              if (wr) begin
                state_q <= StWriteWait;
                cnt_q   <= WriteCnt;
              end else begin
                state_q <= StReadWait;
                cnt_q   <= ReadCnt;
              end
            end
          end
        end
        StReadWait: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            ReadData    <= in_range ? mem[widx] : 32'd0;
            rdata_valid <= 1'b1;
            err         <= !in_range;
            busy        <= 1'b0;
            state_q     <= StIdle;
          end
        end
        StWriteWait: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            write_done <= 1'b1;
            err        <= !in_range;
            busy       <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus random traffic
// checked against a transaction-level memory model.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned RL    = 2;
  localparam int unsigned WL    = 1;
  localparam int unsigned WL3   = 3;

  logic        clk = 1'b0;
  logic        rst, req, wr;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        rvalid, wdone, busy, err;

  logic        rst3, req3;
  logic [31:0] rdata3;
  logic        rvalid3, wdone3, busy3, err3;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .READ_LAT(RL), .WRITE_LAT(WL)) u_dut (
    .Clk(clk), .Reset_signal(rst), .req(req), .wr(wr), .Address(addr), .WriteData(wdata),
    .ReadData(rdata), .rdata_valid(rvalid), .write_done(wdone), .busy(busy), .err(err)
  );

  data_mem_responder #(.DEPTH(DEPTH), .READ_LAT(RL), .WRITE_LAT(WL3)) u_dut3 (
    .Clk(clk), .Reset_signal(rst3), .req(req3), .wr(wr), .Address(addr), .WriteData(wdata),
    .ReadData(rdata3), .rdata_valid(rvalid3), .write_done(wdone3), .busy(busy3), .err(err3)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] mem_model [DEPTH];
  logic [31:0] last_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge of the completion cycle.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input bit junk);
    bit          mis = (a[1:0] != 2'b00);
    bit          oor = ({2'b00, a[31:2]} >= 32'(DEPTH));
    int unsigned lat = w ? WL : RL;
    logic [31:0] exp_rd;
    req = 1'b1; wr = w; addr = a; wdata = d;
    @(posedge clk); #1;
    if (junk) begin
      wr = 1'b1; addr = {22'd0, 8'($urandom), 2'b00}; wdata = $urandom;
    end else begin
      req = 1'b0;
    end
    if (mis) begin
      @(negedge clk);
      chk1("mis_err", err, 1'b1);
      chk1("mis_busy", busy, 1'b0);
      chk1("mis_rvalid", rvalid, 1'b0);
      chk1("mis_wdone", wdone, 1'b0);
      chk("mis_rdata_hold", rdata, last_rdata);
      req = 1'b0;
      return;
    end
    for (int c = 1; c <= int'(lat); c++) begin
      @(negedge clk);
      chk1("wait_busy", busy, 1'b1);
      chk1("wait_rvalid", rvalid, 1'b0);
      chk1("wait_wdone", wdone, 1'b0);
      chk1("wait_err", err, 1'b0);
      if (junk) begin
        addr = {22'd0, 8'($urandom), 2'b00}; wdata = $urandom;
      end
    end
    @(negedge clk);
    chk1("done_busy", busy, 1'b0);
    chk1("done_rvalid", rvalid, !w);
    chk1("done_wdone", wdone, w);
    chk1("done_err", err, oor);
    if (!w) begin
      exp_rd     = oor ? 32'd0 : mem_model[a[9:2]];
      last_rdata = exp_rd;
      chk("read_data", rdata, exp_rd);
    end else begin
      if (!oor) mem_model[a[9:2]] = d;
      chk("write_rdata_hold", rdata, last_rdata);
    end
    req = 1'b0;
  endtask

  initial begin
    logic        rw;
    logic [31:0] ra;
    int          sel;

    for (int i = 0; i < int'(DEPTH); i++) mem_model[i] = 32'd0;
    last_rdata = 32'd0;
    rst = 1'b1; rst3 = 1'b1; req = 1'b0; req3 = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    chk("rst_rdata", rdata, 32'd0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rvalid", rvalid, 1'b0);
    chk1("rst_wdone", wdone, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_busy3", busy3, 1'b0);

    xact(1'b0, 32'h10, 32'h0, 1'b0);
    xact(1'b1, 32'h20, 32'hDEADBEEF, 1'b0);
    xact(1'b0, 32'h20, 32'h0, 1'b0);
    xact(1'b0, 32'h22, 32'h0, 1'b0);
    xact(1'b1, 32'h23, 32'h11111111, 1'b0);
    xact(1'b0, 32'h20, 32'h0, 1'b0);
    xact(1'b1, 32'h400, 32'h12345678, 1'b0);
    xact(1'b0, 32'h400, 32'h0, 1'b0);
    xact(1'b0, 32'h0, 32'h0, 1'b0);
    xact(1'b0, 32'h20, 32'h0, 1'b1);
    xact(1'b0, 32'h10, 32'h0, 1'b0);
    xact(1'b1, 32'h3FC, 32'hA5A55A5A, 1'b0);
    xact(1'b0, 32'h3FC, 32'h0, 1'b0);

    // Aborted write on the WRITE_LAT=3 instance must leave the earlier value intact.
    wr = 1'b1; addr = 32'h30; wdata = 32'h0BADF00D; req3 = 1'b1;
    @(posedge clk); #1 req3 = 1'b0;
    repeat (WL3) @(negedge clk);
    @(negedge clk);
    chk1("pre_wdone3", wdone3, 1'b1);
    wr = 1'b1; addr = 32'h30; wdata = 32'hCAFEF00D; req3 = 1'b1;
    @(posedge clk); #1 req3 = 1'b0;
    @(negedge clk);
    chk1("abort_busy3_pre", busy3, 1'b1);
    rst3 = 1'b1;
    @(posedge clk); #1 rst3 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk1("abort_busy3", busy3, 1'b0);
      chk1("abort_wdone3", wdone3, 1'b0);
    end
    wr = 1'b0; addr = 32'h30; req3 = 1'b1;
    @(posedge clk); #1 req3 = 1'b0;
    repeat (RL) @(negedge clk);
    @(negedge clk);
    chk1("abort_rvalid3", rvalid3, 1'b1);
    chk("abort_rdata3", rdata3, 32'h0BADF00D);

    repeat (80) begin
      rw  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      case (sel)
        0:       ra = {24'd0, 6'($urandom), 2'($urandom_range(1, 3))};
        1:       ra = {(30'(DEPTH) + 30'($urandom_range(0, 1000))), 2'b00};
        2:       ra = 32'((DEPTH - 1) * 4);
        default: ra = 32'($urandom_range(0, 15) * 4);
      endcase
      xact(rw, ra, $urandom, ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
